rifl_axis_rr_arbiter: RTL and testbench
=======================================

// Module: rifl_axis_rr_arbiter
// PURPOSE
//  Round-robin, packet-locked arbiter that lets NUM_REQ AXI-Stream sources share one AXIS sink,
//  normally the write side of a rifl_axis_async_fifo. A grant covers a whole packet and is
//  released only after the tlast beat; a requester mask lets software configure the arbitration
//  pool. The output is registered; the block runs on the single write-side clock.
// PARAMETERS
//  NUM_REQ   4   number of requesting AXIS sources (>=1)
//  DWIDTH    32  tdata width per source and of the output
//  IDW       $clog2(NUM_REQ) (min 1)  width of m_axis_tid / grant_id (localparam)
// PORTS
//  aclk           in   1               single clock for all logic
//  aresetn        in   1               reset; asynchronous assert, active-low
//  s_axis_tdata   in   NUM_REQ*DWIDTH  source data; requester i in bits [i*DWIDTH +: DWIDTH]
//  s_axis_tvalid  in   NUM_REQ         per-source valid
//  s_axis_tlast   in   NUM_REQ         per-source end of packet
//  s_axis_tready  out  NUM_REQ         per-source ready; at most one bit high
//  req_mask       in   NUM_REQ         1 = requester may win arbitration
//  m_axis_tdata   out  DWIDTH          registered output data
//  m_axis_tvalid  out  1               output valid
//  m_axis_tlast   out  1               output end of packet
//  m_axis_tid     out  IDW             index of the source for the current output beat
//  m_axis_tready  in   1               sink ready (FIFO ~full)
//  busy           out  1               1 while in GRANT state
//  grant_id       out  IDW             currently or last granted requester
// BEHAVIOUR
//  Reset (aresetn=0, async): state=IDLE, rr_ptr=0, grant_id=0, busy=0, s_axis_tready=0,
//   m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0. Deassertion is synchronised
//   upstream; the block acts on the first clock edge after aresetn rises.
//  FSM, two states:
//   IDLE : cand = s_axis_tvalid & req_mask. If cand!=0, search indices rr_ptr, rr_ptr+1, ...
//          (mod NUM_REQ) and take the first set bit -> grant_id <= winner, state <= GRANT.
//          Cost is one bubble cycle per packet. No tready is asserted in IDLE.
//   GRANT: s_axis_tready[grant_id] = out_free, where out_free = ~m_axis_tvalid | m_axis_tready.
//          All other tready bits are 0 (combinational from registers and m_axis_tready only).
//          A beat is accepted when s_axis_tvalid[g] & s_axis_tready[g].
//          On acceptance of a beat with tlast=1: state <= IDLE, rr_ptr <= (grant_id+1) mod NUM_REQ.
//  Output register: when out_free, m_axis_tvalid <= accepted; on accept, load tdata/tlast/tid
//   from the granted source. Latency is 1 cycle input->output. Full throughput inside a packet.
//   The output holds stable while m_axis_tvalid & ~m_axis_tready (AXIS rule).
//  Boundaries:
//   - A granted source that drops tvalid mid-packet keeps the grant; no other source is served.
//   - A req_mask bit cleared mid-packet does not abort the packet; it applies from the next IDLE.
//   - req_mask=0 or no valid: stay in IDLE and leave rr_ptr unchanged.
//   - Single-beat packet (tlast on first beat): GRANT lasts exactly 1 cycle if out_free.
//   - Pointer wrap: grant_id=NUM_REQ-1 sets rr_ptr to 0. For NUM_REQ=1, rr_ptr stays 0.
//   - Sink stalled while the tlast beat waits: the grant is held until that beat is accepted.
//   - Reset mid-packet: the beat in the output register is discarded and no partial-packet
//     recovery is attempted (the FIFO reset drops it too).
//  No combinational path from s_axis_* to m_axis_*. tready does not depend on tvalid.
// TESTING
//  1 Reset: hold aresetn=0 with all sources valid -> all tready=0, m_axis_tvalid=0, busy=0;
//    release -> first grant goes to req 0.
//  2 Round robin: NUM_REQ=4, all sources hold 3-beat packets, mask=4'hF, sink always ready ->
//    m_axis_tid sequence 0,0,0,1,1,1,2,2,2,3,3,3,0..., one bubble between packets.
//  3 Packet lock: req1 granted and stalls tvalid for 5 cycles mid-packet while req2 is valid ->
//    no req2 beat appears until req1's tlast is output.
//  4 Backpressure: m_axis_tready toggles 1010... during an 8-beat packet with data 0..7 ->
//    output beats 0..7 in order, none dropped or duplicated, and tdata stable while stalled.
//  5 Mask: mask=4'b0101, all valid -> only ids 0 and 2 are granted, alternating; clear bit 2
//    mid-packet -> that packet completes, and afterwards only id 0 is granted.
//  6 Async reset mid-packet: assert aresetn during beat 3 of 6 -> outputs zero immediately;
//    after release, arbitration restarts from req 0.

Source files
------------

// File: rtl/rifl_axis_rr_arbiter_if.sv
// AXI-Stream bundle for the round-robin arbiter:
// NUM_REQ source lanes in, one registered lane out.
interface rifl_axis_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 32
);
  localparam int IDW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ*DWIDTH-1:0] s_axis_tdata;
  logic [NUM_REQ-1:0]        s_axis_tvalid;
  logic [NUM_REQ-1:0]        s_axis_tlast;
  logic [NUM_REQ-1:0]        s_axis_tready;

  logic [DWIDTH-1:0]         m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tlast;
  logic [IDW-1:0]            m_axis_tid;
  logic                      m_axis_tready;

  // Environment side: drives the sources and the sink ready
  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    input  m_axis_tid,
    output m_axis_tready
  );

  // Arbiter side: consumes the sources, drives the sink
  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    output m_axis_tid,
    input  m_axis_tready
  );
endinterface

// File: rtl/rifl_axis_rr_arbiter.sv
// Round-robin, packet-locked AXIS arbiter.
// NUM_REQ sources share one registered output.
module rifl_axis_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 32,
  localparam int IDW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  rifl_axis_rr_arbiter_if.slave axis,
  input  logic [NUM_REQ-1:0]   req_mask,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     winner;
  logic               found;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] tready;
  logic               out_free;
  logic               accept;
  logic               accept_last;

  // base + k folded back into 0..NUM_REQ-1
  function automatic logic [IDW-1:0] rot_idx(
    input logic [IDW-1:0] base,
    input int             k
  );
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  assign cand     = axis.s_axis_tvalid & req_mask;
  assign out_free = ~axis.m_axis_tvalid
                  | axis.m_axis_tready;
  assign accept   = (state == GRANT) & out_free
                  & axis.s_axis_tvalid[grant_id];
  assign accept_last = accept
                     & axis.s_axis_tlast[grant_id];

  assign axis.s_axis_tready = tready;

  // Rotating priority search starting at rr_ptr
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && cand[rot_idx(rr_ptr, k)]) begin
        found  = 1'b1;
        winner = rot_idx(rr_ptr, k);
      end
    end
  end

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: lock on a winner, release after tlast
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (|cand)      state_nxt = GRANT;
      GRANT: if (accept_last) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // FSM outputs: only the granted lane sees ready
  always_comb begin
    busy   = (state == GRANT);
    tready = '0;
    if (state == GRANT && out_free)
      tready = NUM_REQ'(1) << grant_id;
  end

  // Grant capture and pointer advance past winner
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      if (state == IDLE && found)
        grant_id <= winner;
      if (accept_last)
        rr_ptr <= rot_idx(grant_id, 1);
    end
  end

  // Output register; holds while the sink stalls
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      axis.m_axis_tvalid <= 1'b0;
      axis.m_axis_tdata  <= '0;
      axis.m_axis_tlast  <= 1'b0;
      axis.m_axis_tid    <= '0;
    end else if (out_free) begin
      axis.m_axis_tvalid <= accept;
      if (accept) begin
        axis.m_axis_tdata <= axis.s_axis_tdata[
          int'(grant_id)*DWIDTH +: DWIDTH];
        axis.m_axis_tlast <=
          axis.s_axis_tlast[grant_id];
        axis.m_axis_tid   <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_rifl_axis_rr_arbiter.sv
// Randomised bench for rifl_axis_rr_arbiter:
// cycle model from the arbitration rules plus stream scoreboards.
module tb_rifl_axis_rr_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rifl_axis_rr_arbiter_if #(
    .NUM_REQ(N), .DWIDTH(DW)
  ) axis ();

  logic [N-1:0]   req_mask;
  logic           busy;
  logic [IDW-1:0] grant_id;

  rifl_axis_rr_arbiter #(
    .NUM_REQ(N), .DWIDTH(DW)
  ) dut (
    .aclk(clk),
    .aresetn(rst_n),
    .axis(axis),
    .req_mask(req_mask),
    .busy(busy),
    .grant_id(grant_id)
  );

  int checks = 0;
  int errors = 0;

  // source generators
  int pkt_len[N];
  int beat[N];
  int pkt_no[N];
  int pkts_left[N];
  bit src_en[N];
  bit hold[N];
  bit len_rand;
  int vpct;
  int rpct;
  bit rdy_toggle;
  bit rdy_phase;

  // reference model
  bit          mdl_grant;
  int          mdl_gid;
  int          mdl_ptr;
  bit          mdl_ov;
  bit          mdl_ol;
  logic [DW-1:0] mdl_od;
  int          mdl_oid;

  // output log
  int          log_tid[$];
  logic [DW-1:0] log_dat[$];
  bit          log_last[$];

  bit          prev_stall;
  logic [DW-1:0] prev_dat;

  function automatic logic [DW-1:0] src_data(int i);
    return {8'(i), 8'(pkt_no[i]), 16'(beat[i])};
  endfunction

  function automatic void mdl_reset();
    mdl_grant = 0; mdl_gid = 0; mdl_ptr = 0;
    mdl_ov = 0; mdl_ol = 0; mdl_od = '0;
    mdl_oid = 0; prev_stall = 0;
  endfunction

  function automatic void src_reset();
    for (int i = 0; i < N; i++) begin
      beat[i] = 0; pkt_no[i] = 0; hold[i] = 0;
    end
    log_tid.delete(); log_dat.delete();
    log_last.delete();
  endfunction

  task automatic setup(int len, bit [N-1:0] en,
                       int pkts, int vp, int rp);
    for (int i = 0; i < N; i++) begin
      pkt_len[i] = len; src_en[i] = en[i];
      pkts_left[i] = pkts;
    end
    vpct = vp; rpct = rp;
    rdy_toggle = 0; rdy_phase = 1; len_rand = 0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    mdl_reset(); src_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      axis.s_axis_tdata[i*DW +: DW] = src_data(i);
      axis.s_axis_tlast[i] = (beat[i] == pkt_len[i] - 1);
      axis.s_axis_tvalid[i] = src_en[i] && !hold[i]
        && pkts_left[i] > 0
        && (int'($urandom_range(99)) < vpct);
    end
    if (rdy_toggle) begin
      axis.m_axis_tready = rdy_phase;
      rdy_phase = !rdy_phase;
    end else begin
      axis.m_axis_tready =
        (int'($urandom_range(99)) < rpct);
    end
  endtask

  // one clock: drive, compare against model, step
  task automatic cycle();
    bit free, acc, n_grant, n_ov, n_ol;
    int n_gid, n_ptr, n_oid, idx;
    logic [DW-1:0] n_od;
    logic [N-1:0] exp_rdy, cand, fire;
    bit ofire, stall;
    logic [DW-1:0] odat;
    int otid;
    bit olast;
    drive();
    #1;
    free = !mdl_ov || axis.m_axis_tready;
    exp_rdy = '0;
    if (mdl_grant && free) exp_rdy[mdl_gid] = 1'b1;
    checks++;
    if (axis.s_axis_tready !== exp_rdy) begin
      errors++;
      $display("FAIL tready: got %b want %b",
               axis.s_axis_tready, exp_rdy);
    end
    checks++;
    if (busy !== mdl_grant) begin
      errors++;
      $display("FAIL busy: got %b want %b",
               busy, mdl_grant);
    end
    checks++;
    if (grant_id !== IDW'(mdl_gid)) begin
      errors++;
      $display("FAIL grant_id: got %0d want %0d",
               grant_id, mdl_gid);
    end
    checks++;
    if (axis.m_axis_tvalid !== mdl_ov) begin
      errors++;
      $display("FAIL m_tvalid: got %b want %b",
               axis.m_axis_tvalid, mdl_ov);
    end
    if (mdl_ov) begin
      checks++;
      if (axis.m_axis_tdata !== mdl_od
          || axis.m_axis_tlast !== mdl_ol
          || axis.m_axis_tid !== IDW'(mdl_oid)) begin
        errors++;
        $display("FAIL m_beat: got %h/%b/%0d want %h/%b/%0d",
                 axis.m_axis_tdata, axis.m_axis_tlast,
                 axis.m_axis_tid, mdl_od, mdl_ol, mdl_oid);
      end
    end
    if (prev_stall) begin
      checks++;
      if (axis.m_axis_tdata !== prev_dat) begin
        errors++;
        $display("FAIL stall_hold: got %h want %h",
                 axis.m_axis_tdata, prev_dat);
      end
    end
    acc = mdl_grant && free
       && axis.s_axis_tvalid[mdl_gid];
    n_grant = mdl_grant; n_gid = mdl_gid;
    n_ptr = mdl_ptr; n_ov = mdl_ov; n_ol = mdl_ol;
    n_od = mdl_od; n_oid = mdl_oid;
    if (!mdl_grant) begin
      cand = axis.s_axis_tvalid & req_mask;
      for (int k = 0; k < N; k++) begin
        idx = (mdl_ptr + k) % N;
        if (!n_grant && cand[idx]) begin
          n_grant = 1; n_gid = idx;
        end
      end
    end else if (acc
        && beat[mdl_gid] == pkt_len[mdl_gid] - 1) begin
      n_grant = 0;
      n_ptr = (mdl_gid + 1) % N;
    end
    if (free) begin
      n_ov = acc;
      if (acc) begin
        n_od = src_data(mdl_gid);
        n_ol = (beat[mdl_gid] == pkt_len[mdl_gid] - 1);
        n_oid = mdl_gid;
      end
    end
    fire = axis.s_axis_tvalid & axis.s_axis_tready;
    ofire = axis.m_axis_tvalid && axis.m_axis_tready;
    stall = axis.m_axis_tvalid && !axis.m_axis_tready;
    odat = axis.m_axis_tdata;
    otid = int'(axis.m_axis_tid);
    olast = axis.m_axis_tlast;
    @(posedge clk);
    mdl_grant = n_grant; mdl_gid = n_gid;
    mdl_ptr = n_ptr; mdl_ov = n_ov; mdl_ol = n_ol;
    mdl_od = n_od; mdl_oid = n_oid;
    prev_stall = stall; prev_dat = odat;
    if (ofire) begin
      log_tid.push_back(otid);
      log_dat.push_back(odat);
      log_last.push_back(olast);
    end
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        beat[i]++;
        if (beat[i] == pkt_len[i]) begin
          beat[i] = 0; pkt_no[i]++; pkts_left[i]--;
          if (len_rand)
            pkt_len[i] = int'($urandom_range(1, 5));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    setup(3, 4'hF, 1000, 100, 100);
    req_mask = 4'hF;
    rst_n = 1'b0;
    mdl_reset(); src_reset();
    drive();
    #1;
    checks++;
    if (axis.s_axis_tready !== 4'b0 || busy !== 1'b0
        || axis.m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: rdy %b busy %b v %b want 0",
               axis.s_axis_tready, busy,
               axis.m_axis_tvalid);
    end
    checks++;
    if (axis.m_axis_tdata !== '0 || axis.m_axis_tlast !== 1'b0
        || axis.m_axis_tid !== '0 || grant_id !== '0) begin
      errors++;
      $display("FAIL reset_dat: d %h l %b id %0d g %0d want 0",
               axis.m_axis_tdata, axis.m_axis_tlast,
               axis.m_axis_tid, grant_id);
    end
    @(posedge clk);
    #1;
    checks++;
    if (axis.s_axis_tready !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: rdy %b busy %b want 0",
               axis.s_axis_tready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checks++;
    if (grant_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: g %0d busy %b want 0/1",
               grant_id, busy);
    end
    repeat (4) cycle();
  endtask

  task automatic test_round_robin();
    setup(3, 4'hF, 1000, 100, 100);
    req_mask = 4'hF;
    reset_dut();
    repeat (64) cycle();
    checks++;
    if (log_tid.size() < 45) begin
      errors++;
      $display("FAIL rr_count: got %0d want >=45",
               log_tid.size());
    end
    for (int k = 0; k < log_tid.size(); k++) begin
      checks++;
      if (log_tid[k] != (k / 3) % 4
          || log_last[k] != (k % 3 == 2)) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got %0d/%b want %0d/%b",
                 k, log_tid[k], log_last[k],
                 (k / 3) % 4, (k % 3 == 2));
      end
    end
  endtask

  task automatic test_packet_lock();
    int n, start;
    bit seen;
    setup(4, 4'hF, 1000, 100, 100);
    req_mask = 4'hF;
    reset_dut();
    n = 0;
    while (!(busy && grant_id == 2'd1 && beat[1] == 1)
           && n < 100) begin
      cycle(); n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL lock_wait: got timeout want grant 1");
    end
    start = log_tid.size();
    hold[1] = 1;
    repeat (5) cycle();
    hold[1] = 0;
    repeat (20) cycle();
    seen = 0;
    for (int k = start; k < log_tid.size(); k++) begin
      if (!seen) begin
        checks++;
        if (log_tid[k] != 1) begin
          errors++;
          $display("FAIL lock_beat[%0d]: got %0d want 1",
                   k, log_tid[k]);
        end
        if (log_last[k]) seen = 1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL lock_last: got none want req1 tlast");
    end
  endtask

  task automatic test_backpressure();
    setup(8, 4'b0001, 1, 100, 100);
    req_mask = 4'hF;
    reset_dut();
    rdy_toggle = 1;
    repeat (40) cycle();
    checks++;
    if (log_tid.size() != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d want 8",
               log_tid.size());
    end
    for (int k = 0; k < log_tid.size(); k++) begin
      checks++;
      if (log_dat[k] != DW'(k)
          || log_last[k] != (k == 7)) begin
        errors++;
        $display("FAIL bp_beat[%0d]: got %h/%b want %h/%b",
                 k, log_dat[k], log_last[k], k, (k == 7));
      end
    end
  endtask

  task automatic test_mask();
    int p, n, fl;
    setup(3, 4'hF, 1000, 100, 100);
    req_mask = 4'b0101;
    reset_dut();
    repeat (40) cycle();
    p = 0;
    for (int k = 0; k < log_tid.size(); k++) begin
      if (log_last[k]) begin
        checks++;
        if (log_tid[k] != (p % 2) * 2) begin
          errors++;
          $display("FAIL mask_pkt[%0d]: got %0d want %0d",
                   p, log_tid[k], (p % 2) * 2);
        end
        p++;
      end
    end
    n = 0;
    while (!(busy && grant_id == 2'd2) && n < 20) begin
      cycle(); n++;
    end
    req_mask = 4'b0001;
    log_tid.delete(); log_dat.delete();
    log_last.delete();
    repeat (30) cycle();
    fl = -1;
    for (int k = 0; k < log_tid.size(); k++)
      if (fl < 0 && log_last[k]) fl = k;
    checks++;
    if (fl < 0 || fl + 3 >= log_tid.size()) begin
      errors++;
      $display("FAIL mask_clr: got last at %0d of %0d",
               fl, log_tid.size());
    end
    for (int k = 0; k < log_tid.size(); k++) begin
      checks++;
      if (log_tid[k] != ((k <= fl) ? 2 : 0)) begin
        errors++;
        $display("FAIL mask_clr[%0d]: got %0d want %0d",
                 k, log_tid[k], (k <= fl) ? 2 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    setup(6, 4'b0011, 1000, 100, 100);
    req_mask = 4'hF;
    reset_dut();
    n = 0;
    while (!(axis.m_axis_tvalid && axis.m_axis_tid == 2'd1
             && axis.m_axis_tdata[15:0] == 16'd2)
           && n < 40) begin
      cycle(); n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL rmid_wait: got timeout want beat 3");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (axis.m_axis_tvalid !== 1'b0
        || axis.m_axis_tdata !== '0
        || axis.m_axis_tlast !== 1'b0
        || axis.m_axis_tid !== '0
        || busy !== 1'b0 || grant_id !== '0
        || axis.s_axis_tready !== '0) begin
      errors++;
      $display("FAIL rmid_zero: v %b d %h id %0d b %b g %0d want 0",
               axis.m_axis_tvalid, axis.m_axis_tdata,
               axis.m_axis_tid, busy, grant_id);
    end
    mdl_reset(); src_reset();
    setup(6, 4'hF, 1000, 100, 100);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checks++;
    if (grant_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_restart: g %0d b %b want 0/1",
               grant_id, busy);
    end
    repeat (10) cycle();
  endtask

  task automatic test_random();
    int ep[N];
    int eb[N];
    int t;
    setup(3, 4'hF, 100000, 70, 60);
    len_rand = 1;
    for (int i = 0; i < N; i++)
      pkt_len[i] = int'($urandom_range(1, 5));
    req_mask = 4'hF;
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 149)
        req_mask = N'($urandom_range(0, 15));
      cycle();
    end
    for (int i = 0; i < N; i++) begin
      ep[i] = 0; eb[i] = 0;
    end
    checks++;
    if (log_tid.size() < 500) begin
      errors++;
      $display("FAIL rnd_count: got %0d want >=500",
               log_tid.size());
    end
    for (int k = 0; k < log_tid.size(); k++) begin
      t = log_tid[k];
      checks++;
      if (log_dat[k] !== {8'(t), 8'(ep[t]), 16'(eb[t])})
      begin
        errors++;
        $display("FAIL rnd_order[%0d]: got %h want %h",
                 k, log_dat[k],
                 {8'(t), 8'(ep[t]), 16'(eb[t])});
      end
      if (k > 0 && !log_last[k-1]) begin
        checks++;
        if (t != log_tid[k-1]) begin
          errors++;
          $display("FAIL rnd_lock[%0d]: got %0d want %0d",
                   k, t, log_tid[k-1]);
        end
      end
      eb[t]++;
      if (log_last[k]) begin
        ep[t]++; eb[t] = 0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_mask = '0;
    axis.s_axis_tdata  = '0;
    axis.s_axis_tvalid = '0;
    axis.s_axis_tlast  = '0;
    axis.m_axis_tready = 1'b0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_mask();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
